// File: rtl/queue_counter_if.sv
// Sensor inputs and occupancy/status outputs of the queue counter.
// The master side drives the raw sensors; the slave side drives the count and status.
interface queue_counter_if #(
  parameter int CW = 4
);
  logic          back_sensor;
  logic          front_sensor;
  logic [CW-1:0] pcount;
  logic          empty;
  logic          full;
  logic          ovf_pulse;
  logic          unf_pulse;
  logic          err_sticky;

  modport master (
    output back_sensor, front_sensor,
    input  pcount, empty, full, ovf_pulse, unf_pulse, err_sticky
  );

  modport slave (
    input  back_sensor, front_sensor,
    output pcount, empty, full, ovf_pulse, unf_pulse, err_sticky
  );
endinterface

// File: rtl/queue_counter.sv
// Queue occupancy counter: synchronises and debounces the entry/exit photo-sensors,
// then tracks occupancy with a saturating EMPTY/PARTIAL/FULL state machine.
module queue_counter #(
  parameter int CAPACITY   = 7,
  parameter int DEB_CYCLES = 4,
  parameter int CW         = 4
) (
  input logic           clk,
  input logic           rst,
  queue_counter_if.slave qif
);
  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  localparam logic [CW-1:0] CAP      = CW'(CAPACITY);
  localparam logic [3:0]    DEB_LAST = 4'(DEB_CYCLES - 1);

  // Index 0 is the entry (back) sensor, index 1 the exit (front) sensor.
  logic [1:0] raw;
  logic [1:0] ev;

  assign raw = {qif.front_sensor, qif.back_sensor};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
      logic       s1_q, s2_q, acc_q, prev_q;
      logic       acc_d;
      logic [3:0] cnt_q, cnt_d;

      always_comb begin
        acc_d = acc_q;
        cnt_d = 4'd0;
        if (s2_q != acc_q) begin
          if (cnt_q == DEB_LAST) begin
            acc_d = s2_q;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_q   <= 1'b0;
          s2_q   <= 1'b0;
          acc_q  <= 1'b0;
          prev_q <= 1'b0;
          cnt_q  <= 4'd0;
        end else begin
          s1_q   <= raw[gi];
          s2_q   <= s1_q;
          acc_q  <= acc_d;
          prev_q <= acc_q;
          cnt_q  <= cnt_d;
        end
      end

      assign ev[gi] = acc_q & ~prev_q;
    end
  endgenerate

  logic          ent, ext;
  state_t        state_q, state_d;
  logic [CW-1:0] pcount_q, pcount_d;
  logic [CW-1:0] pc_inc, pc_dec;
  logic          empty_q, empty_d, full_q, full_d;
  logic          ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;

  assign ent    = ev[0];
  assign ext    = ev[1];
  assign pc_inc = pcount_q + CW'(1);
  assign pc_dec = pcount_q - CW'(1);

  // A simultaneous entry and exit nets to zero in every state, so only lone events act.
  always_comb begin
    state_d  = state_q;
    pcount_d = pcount_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (ent && !ext) begin
      case (state_q)
        S_EMPTY: begin
          pcount_d = CW'(1);
          state_d  = (CAP == CW'(1)) ? S_FULL : S_PARTIAL;
        end
        S_PARTIAL: begin
          pcount_d = pc_inc;
          state_d  = (pc_inc == CAP) ? S_FULL : S_PARTIAL;
        end
        S_FULL:  ovf_d = 1'b1;
        default: state_d = S_EMPTY;
      endcase
    end else if (ext && !ent) begin
      case (state_q)
        S_FULL, S_PARTIAL: begin
          pcount_d = pc_dec;
          state_d  = (pc_dec == '0) ? S_EMPTY : S_PARTIAL;
        end
        S_EMPTY: unf_d = 1'b1;
        default: state_d = S_EMPTY;
      endcase
    end
    empty_d = (state_d == S_EMPTY);
    full_d  = (state_d == S_FULL);
    err_d   = err_q | ovf_d | unf_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      pcount_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcount_q <= pcount_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      err_q    <= err_d;
    end
  end

  assign qif.pcount     = pcount_q;
  assign qif.empty      = empty_q;
  assign qif.full       = full_q;
  assign qif.ovf_pulse  = ovf_q;
  assign qif.unf_pulse  = unf_q;
  assign qif.err_sticky = err_q;
endmodule

// File: tb/tb_queue_counter.sv
// Scoreboard bench for queue_counter: tasks push expected output events, a negedge
// monitor pops and compares whenever pcount changes or an error pulse fires.
module tb_queue_counter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] sb[$];
  logic [3:0] prev_pc;

  queue_counter_if #(.CW(4)) qif ();

  queue_counter #(.CAPACITY(7), .DEB_CYCLES(4), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .qif (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ev_pack(int pc, bit e, bit f, bit o, bit u);
    logic [3:0] p;
    p = 4'(pc);
    return {p, e, f, o, u};
  endfunction

  // Output event = any pcount change or any error pulse outside reset.
  always @(negedge clk) begin
    logic [7:0] obs;
    logic [7:0] exp_v;
    obs = {qif.pcount, qif.empty, qif.full, qif.ovf_pulse, qif.unf_pulse};
    if (rst) begin
      prev_pc = qif.pcount;
    end else if (qif.pcount !== prev_pc || qif.ovf_pulse || qif.unf_pulse) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event t=%0t got pc=%0d e=%b f=%b ovf=%b unf=%b required none",
                 $time, obs[7:4], obs[3], obs[2], obs[1], obs[0]);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL event t=%0t got pc/e/f/ovf/unf=%h required %h", $time, obs, exp_v);
        end else begin
          $display("event t=%0t pc=%0d e=%b f=%b ovf=%b unf=%b ok",
                   $time, obs[7:4], obs[3], obs[2], obs[1], obs[0]);
        end
      end
      prev_pc = qif.pcount;
    end
  end

  task automatic wait_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    qif.back_sensor  = 1'b0;
    qif.front_sensor = 1'b0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic pulse(bit b, bit f, int hi, int lo);
    @(negedge clk);
    qif.back_sensor  = b;
    qif.front_sensor = f;
    wait_cycles(hi);
    qif.back_sensor  = 1'b0;
    qif.front_sensor = 1'b0;
    wait_cycles(lo);
  endtask

  task automatic check_drained(string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drained got %0d pending events required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    qif.back_sensor  = 1'b1;
    qif.front_sensor = 1'b1;
    wait_cycles(2);
    checks++;
    if ({qif.pcount, qif.empty, qif.full, qif.ovf_pulse, qif.unf_pulse} !== ev_pack(0, 1, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_outputs got pc=%0d e=%b f=%b required pc=0 e=1 f=0",
               qif.pcount, qif.empty, qif.full);
    end
    checks++;
    if (qif.err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got %b required 0", qif.err_sticky);
    end
    rst = 1'b0;
    wait_cycles(12);
    checks++;
    if (qif.pcount !== 4'd0 || qif.err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL reset_pair got pc=%0d err=%b required pc=0 err=0", qif.pcount, qif.err_sticky);
    end
    qif.back_sensor  = 1'b0;
    qif.front_sensor = 1'b0;
    wait_cycles(10);
    check_drained("reset");
  endtask

  task automatic test_single_entry();
    int first_idx;
    do_reset();
    first_idx = -1;
    sb.push_back(ev_pack(1, 0, 0, 0, 0));
    @(negedge clk);
    qif.back_sensor = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (first_idx < 0 && qif.pcount == 4'd1) first_idx = i;
    end
    qif.back_sensor = 1'b0;
    checks++;
    if (first_idx != 6) begin
      failures++;
      $display("FAIL entry_latency got edge k+%0d required k+6", first_idx);
    end
    wait_cycles(10);
    checks++;
    if (qif.pcount !== 4'd1 || qif.empty !== 1'b0) begin
      failures++;
      $display("FAIL entry_hold got pc=%0d e=%b required pc=1 e=0", qif.pcount, qif.empty);
    end
    check_drained("single_entry");
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      if (n <= 7) sb.push_back(ev_pack(n, 0, (n == 7), 0, 0));
      else        sb.push_back(ev_pack(7, 0, 1, 1, 0));
      pulse(1'b1, 1'b0, 8, 8);
    end
    checks++;
    if (qif.pcount !== 4'd7 || qif.full !== 1'b1 || qif.err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL overflow_final got pc=%0d f=%b err=%b required pc=7 f=1 err=1",
               qif.pcount, qif.full, qif.err_sticky);
    end
    check_drained("fill_overflow");
  endtask

  task automatic test_underflow();
    do_reset();
    sb.push_back(ev_pack(0, 1, 0, 0, 1));
    pulse(1'b0, 1'b1, 8, 8);
    checks++;
    if (qif.pcount !== 4'd0 || qif.err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL underflow got pc=%0d err=%b required pc=0 err=1", qif.pcount, qif.err_sticky);
    end
    sb.push_back(ev_pack(1, 0, 0, 0, 0));
    pulse(1'b1, 1'b0, 8, 8);
    checks++;
    if (qif.pcount !== 4'd1 || qif.err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL after_underflow got pc=%0d err=%b required pc=1 err=1", qif.pcount, qif.err_sticky);
    end
    check_drained("underflow");
  endtask

  task automatic test_glitch();
    do_reset();
    pulse(1'b1, 1'b0, 3, 12);
    checks++;
    if (qif.pcount !== 4'd0 || qif.err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL glitch got pc=%0d err=%b required pc=0 err=0", qif.pcount, qif.err_sticky);
    end
    for (int n = 1; n <= 7; n++) begin
      sb.push_back(ev_pack(n, 0, (n == 7), 0, 0));
      pulse(1'b1, 1'b0, 8, 8);
    end
    pulse(1'b1, 1'b1, 8, 8);
    checks++;
    if (qif.pcount !== 4'd7 || qif.full !== 1'b1 || qif.err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL full_pair got pc=%0d f=%b err=%b required pc=7 f=1 err=0",
               qif.pcount, qif.full, qif.err_sticky);
    end
    check_drained("glitch");
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int n = 1; n <= 3; n++) begin
      sb.push_back(ev_pack(n, 0, 0, 0, 0));
      pulse(1'b1, 1'b0, 8, 8);
    end
    @(negedge clk);
    qif.back_sensor = 1'b1;
    wait_cycles(2);
    rst = 1'b1;
    qif.back_sensor = 1'b0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(15);
    checks++;
    if (qif.pcount !== 4'd0 || qif.empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_midop got pc=%0d e=%b required pc=0 e=1", qif.pcount, qif.empty);
    end
    check_drained("reset_midop");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    prev_pc  = 4'd0;
    qif.back_sensor  = 1'b0;
    qif.front_sensor = 1'b0;
    test_reset();
    test_single_entry();
    test_fill_overflow();
    test_underflow();
    test_glitch();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/queue_counter.md
Name: queue_counter

Overview:
- Upstream feeder for the waiting-time lookup stage: counts people currently in the queue and drives the 4-bit people-count bus consumed by that lookup.
- Two photo-sensor inputs: one at the queue back (entry) and one at the queue front (exit, person served).
- Each sensor is synchronised, debounced and rising-edge qualified.
- A saturating up/down counter with EMPTY/PARTIAL/FULL state tracking drives the count, plus status and error outputs.

Parameters:
- CAPACITY, 7, maximum legal queue occupancy. The downstream lookup table is defined for counts 0..7 only.
- DEB_CYCLES, 4, consecutive synchronised cycles a sensor level must hold before it is accepted (legal range 1..15).
- CW, 4, width of the people-count output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- back_sensor  input  1  raw asynchronous entry sensor; high while a person is detected.
- front_sensor  input  1  raw asynchronous exit sensor; high while a person is detected.
- pcount  output  CW  registered current occupancy, 0..CAPACITY.
- empty  output  1  registered; high when pcount == 0.
- full  output  1  registered; high when pcount == CAPACITY.
- ovf_pulse  output  1  one-cycle pulse when an entry is rejected because the queue is full.
- unf_pulse  output  1  one-cycle pulse when an exit is rejected because the queue is empty.
- err_sticky  output  1  set by either pulse; cleared only by rst.

Behaviour:
- Reset (rst high at a clock edge):
  - pcount=0, empty=1, full=0, ovf_pulse=0, unf_pulse=0, err_sticky=0.
  - Synchroniser flops, debounce counters, accepted levels and previous levels all clear to 0.
  - FSM enters S_EMPTY.
  - Reset mid-debounce or mid-event discards any pending event.
- Synchroniser: a 2-flop chain per sensor; s2 is the synchronised level.
- Debounce, per sensor, each edge:
  - If s2 == accepted level: cnt <= 0.
  - Else if cnt == DEB_CYCLES-1: accepted <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A pulse that drops before acceptance resets cnt and is ignored.
- Event detection:
  - ev = accepted & ~accepted_prev, where accepted_prev is registered every cycle.
  - Only the 0->1 transition counts; a sensor held high produces exactly one event.
  - Falling edges produce no event.
- Latency: if a raw input is first sampled high at edge k and stays high, pcount changes at edge k+DEB_CYCLES+2.
- FSM (states S_EMPTY, S_PARTIAL, S_FULL), with ent = back event and ext = front event:
  - ent & ext, any state: pcount unchanged, no error pulse. One person in and one out nets zero, even in S_EMPTY and S_FULL.
  - ent only:
    - S_EMPTY -> pcount=1; go to S_PARTIAL, or S_FULL if CAPACITY==1.
    - S_PARTIAL -> pcount+1; go to S_FULL when the result equals CAPACITY.
    - S_FULL -> pcount held, ovf_pulse=1 for one cycle.
  - ext only:
    - S_FULL -> pcount-1, go to S_PARTIAL.
    - S_PARTIAL -> pcount-1; go to S_EMPTY when the result is 0.
    - S_EMPTY -> pcount held, unf_pulse=1 for one cycle.
  - No event: all state held; pulses 0.
- Outputs:
  - empty and full are decoded from the next state and registered with pcount, so they are never inconsistent with pcount in the same cycle.
  - pcount never wraps and never exceeds CAPACITY; upper bits above CAPACITY are always 0.
- err_sticky <= err_sticky | ovf_pulse | unf_pulse, evaluated on the same edge as the pulse.

Test Plan:
- Reset: hold rst 2 cycles with both sensors high -> pcount=0, empty=1, full=0, err_sticky=0; after release, with sensors still high, exactly one entry and one exit are accepted as a simultaneous pair -> pcount stays 0, no pulses.
- Single entry (DEB_CYCLES=4): back_sensor high for 10 cycles starting at edge k -> pcount 0->1 at edge k+6, empty drops on the same edge, no further increments while held.
- Fill and overflow: 8 separate back_sensor pulses, each 8 cycles high and 8 low -> pcount 1..7, full=1 after the 7th; 8th pulse -> pcount stays 7, ovf_pulse high exactly 1 cycle, err_sticky=1.
- Underflow: from reset, one front_sensor pulse -> pcount 0, unf_pulse 1 cycle, err_sticky=1; then a back pulse -> pcount=1, err_sticky still 1.
- Glitch rejection: back_sensor high 3 cycles, then low (DEB_CYCLES=4) -> pcount unchanged, no pulses; with pcount=7, simultaneous front and back pulses -> pcount 7, no ovf_pulse.
- Reset mid-operation: pcount=3, back_sensor rises, rst asserted 2 cycles later -> pcount=0 after reset, no late increment after rst releases while the sensor is low.
